// File: rtl/stepper_pkg.sv
// Shared definitions for the step/direction sequencer: sequencer states,
// default widths and a small width helper.
package stepper_pkg;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_PER_W   = 6;
   localparam int DEF_PULSE_W = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter shared by the STEP high and low phases; expire flags
// the last cycle of the loaded duration and the count never wraps below zero.
module step_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic         expire
);

   logic [W-1:0] r_cnt;

   // NOTE: non-blocking assignments in clocked logic, so every register
   // updates from the values present before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= value;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign expire = (r_cnt == '0);

endmodule

// File: rtl/stepper_step_seq.sv
// Step/direction sequencer for one axis: takes a move command over valid/ready
// and plays out a registered STEP pulse train with a held DIR level.
module stepper_step_seq
   import stepper_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PER_W   = DEF_PER_W,
   parameter int PULSE_W = DEF_PULSE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [PER_W-1:0] cmd_period,
   input  logic             abort,
   output logic             step,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] steps_left
);

   localparam int TMR_W = max_int(PER_W, $clog2(PULSE_W + 1));

   state_t             r_state;
   state_t             w_next;
   logic [PER_W-1:0]   r_period;
   logic               r_abort_pend;
   logic               w_accept;
   logic               w_abort_exit;
   logic               w_expire;
   logic               w_load;
   logic [TMR_W-1:0]   w_load_val;
   logic               w_tmr_en;

   assign cmd_ready = rst && (r_state == IDLE);
   assign w_accept  = cmd_valid && cmd_ready;

   // NOTE: defaults are assigned first so every path drives w_next and
   // w_abort_exit, and no latch is inferred.
   always_comb begin
      w_next       = r_state;
      w_abort_exit = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = (cmd_steps == '0) ? DONE : SETUP;
         end
         SETUP: begin
            if (abort) begin
               w_next       = DONE;
               w_abort_exit = 1'b1;
            end else begin
               w_next = HIGH;
            end
         end
         HIGH: begin
            // an abort seen anywhere in the pulse only takes effect once it completes
            if (w_expire) begin
               if (abort || r_abort_pend) begin
                  w_next       = DONE;
                  w_abort_exit = 1'b1;
               end else begin
                  w_next = LOW;
               end
            end
         end
         LOW: begin
            if (w_expire && (steps_left == '0)) begin
               w_next = DONE;
            end else if (abort) begin
               w_next       = DONE;
               w_abort_exit = 1'b1;
            end else if (w_expire) begin
               w_next = HIGH;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The timer is reloaded only when entering a timed phase.
   assign w_load     = (w_next != r_state) && ((w_next == HIGH) || (w_next == LOW));
   assign w_load_val = (w_next == HIGH) ? TMR_W'(PULSE_W - 1)
                                        : TMR_W'(r_period - PER_W'(1));
   assign w_tmr_en   = (r_state == HIGH) || (r_state == LOW);

   step_timer #(.W(TMR_W)) u_timer (
      .clk    (clk),
      .rst_n  (rst),
      .load   (w_load),
      .value  (w_load_val),
      .en     (w_tmr_en),
      .expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_period     <= PER_W'(1);
         r_abort_pend <= 1'b0;
         step         <= 1'b0;
         dir          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         steps_left   <= '0;
      end else begin
         r_state <= w_next;
         step    <= (w_next == HIGH);
         busy    <= (w_next != IDLE);
         done    <= (w_next == DONE);
         r_abort_pend <= ((r_state == HIGH) && (w_next == HIGH)) ? (abort || r_abort_pend) : 1'b0;

         if (w_accept) begin
            dir        <= cmd_dir;
            steps_left <= cmd_steps;
            r_period   <= (cmd_period == '0) ? PER_W'(1) : cmd_period;
            aborted    <= 1'b0;
         end
         if (w_abort_exit) aborted <= 1'b1;
         if ((r_state == HIGH) && w_expire && (steps_left != '0)) begin
            steps_left <= steps_left - CNT_W'(1);
         end
      end
   end

endmodule
